// File: rtl/exc_pkg.sv
// Exception bit map, FSM state encoding and fault-merge helper for the MEM-stage exception collector.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package exc_pkg;

    localparam int EXC_W = 8;

    // Bit positions in the CP0 exc_type vector
    localparam int EXC_BP   = 0;
    localparam int EXC_SYS  = 1;
    localparam int EXC_RI   = 2;
    localparam int EXC_OV   = 3;
    localparam int EXC_TR   = 4;
    localparam int EXC_ERET = 5;
    localparam int EXC_ADEL = 6;
    localparam int EXC_ADES = 7;

    localparam logic [EXC_W-1:0] EXC_NONE = '0;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    // Fold MEM-stage address faults into the upstream flags. A fetch AdEL is
    // already in exc[EXC_ADEL], so a load misalignment only adds the bit when
    // it is not set yet; the OR result is the same either way.
    function automatic logic [EXC_W-1:0] merge_mem_faults(
        input logic [EXC_W-1:0] exc,
        input logic             load_mis,
        input logic             store_mis
    );
        logic [EXC_W-1:0] f;
        f           = EXC_NONE;
        f[EXC_ADES] = store_mis;
        f[EXC_ADEL] = load_mis & ~exc[EXC_ADEL];
        return exc | f;
    endfunction

endpackage

// File: rtl/exc_mem_reg.sv
// MEM-stage payload register (valid, PC, delay-slot flag, exception flags) fed from EX.
// Latency: one cycle from EX inputs to MEM outputs.
// Backpressure: stall holds the register; flush clears valid and overrides stall.
module exc_mem_reg
    import exc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_ds,
    input  logic [EXC_W-1:0] ex_exc,
    output logic             mem_valid,
    output logic [31:0]      mem_pc,
    output logic             mem_ds,
    output logic [EXC_W-1:0] mem_exc
);

    // Advance EX into MEM when not stalled; a flush kills the entry even under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_pc    <= '0;
            mem_ds    <= 1'b0;
            mem_exc   <= EXC_NONE;
        end else begin
            if (!stall) begin
                mem_valid <= ex_valid;
                mem_pc    <= ex_pc;
                mem_ds    <= ex_ds;
                mem_exc   <= ex_exc;
            end
            if (flush) begin
                mem_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception collector feeding CP0, plus flush and fetch-redirect sequencing on exc_en.
// Latency: exc_type/victim combinational from the MEM register; flush same cycle as exc_en; redirect from next cycle.
// Backpressure: redirect valid/pc held until redirect_ready; exceptions are accepted regardless of stall.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             ex_valid_i,
    input  logic [31:0]      ex_pc_i,
    input  logic             ex_is_delayslot_i,
    input  logic [EXC_W-1:0] ex_exc_i,
    input  logic [31:0]      oldest_pc_i,
    input  logic             oldest_is_delayslot_i,
    input  logic [31:0]      mem_addr_i,
    input  logic             mem_load_mis_i,
    input  logic             mem_store_mis_i,
    input  logic             exc_en_i,
    input  logic [31:0]      pc_exc_i,
    input  logic             redirect_ready_i,
    output logic [EXC_W-1:0] exc_type_o,
    output logic [31:0]      victim_pc_o,
    output logic             is_delayslot_o,
    output logic [31:0]      badvaddr_o,
    output logic             flush_o,
    output logic             mem_we_kill_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] exc_count_o
);

    state_t             state;
    logic [31:0]        redirect_pc_q;
    logic [CNT_W-1:0]   exc_count_q;
    logic               seen_q;

    logic               mem_valid;
    logic [31:0]        mem_pc;
    logic               mem_ds;
    logic [EXC_W-1:0]   mem_exc;

    exc_mem_reg u_mem_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall_i),
        .flush     (flush_o),
        .ex_valid  (ex_valid_i),
        .ex_pc     (ex_pc_i),
        .ex_ds     (ex_is_delayslot_i),
        .ex_exc    (ex_exc_i),
        .mem_valid (mem_valid),
        .mem_pc    (mem_pc),
        .mem_ds    (mem_ds),
        .mem_exc   (mem_exc)
    );

    // CP0 commits in the same cycle it sees exc_type, so flush and the MEM
    // side-effect kill must follow exc_en combinationally.
    assign flush_o          = exc_en_i | (state == REDIRECT);
    assign mem_we_kill_o    = exc_en_i & (state == IDLE);
    assign redirect_valid_o = (state == REDIRECT);
    assign redirect_pc_o    = redirect_pc_q;
    assign exc_count_o      = exc_count_q;
    assign badvaddr_o       = mem_addr_i;

    // Only a live MEM instruction in IDLE may raise an exception to CP0
    always_comb begin
        exc_type_o = EXC_NONE;
        if (state == IDLE && mem_valid) begin
            exc_type_o = merge_mem_faults(mem_exc, mem_load_mis_i, mem_store_mis_i);
        end
    end

    // Victim is the oldest thing CP0 could be interrupting, with RESET_PC before any instruction exists
    always_comb begin
        victim_pc_o    = RESET_PC;
        is_delayslot_o = 1'b0;
        if (state == REDIRECT) begin
            victim_pc_o = redirect_pc_q;
        end else if (mem_valid) begin
            victim_pc_o    = mem_pc;
            is_delayslot_o = mem_ds;
        end else if (ex_valid_i) begin
            victim_pc_o    = ex_pc_i;
            is_delayslot_o = ex_is_delayslot_i;
        end else if (seen_q) begin
            victim_pc_o    = oldest_pc_i;
            is_delayslot_o = oldest_is_delayslot_i;
        end
    end

    // Sticky marker: the IF/ID oldest PC is meaningful once any instruction has flowed down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else if (ex_valid_i || mem_valid) begin
            seen_q <= 1'b1;
        end
    end

    // Redirect FSM: capture the CP0 target, count exceptions, hold the request until fetch accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            redirect_pc_q <= '0;
            exc_count_q   <= '0;
        end else begin
            if (exc_en_i && exc_count_q != {CNT_W{1'b1}}) begin
                exc_count_q <= exc_count_q + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (exc_en_i) begin
                        redirect_pc_q <= pc_exc_i;
                        state         <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    // A new CP0 target (interrupt right after ERET) supersedes an in-flight handshake
                    if (exc_en_i) begin
                        redirect_pc_q <= pc_exc_i;
                    end else if (redirect_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
    import exc_pkg::*;

    localparam logic [31:0] RST_PC = 32'hbfc00000;
    localparam logic [31:0] VEC    = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_is_delayslot_i;
    logic [7:0]  ex_exc_i;
    logic [31:0] oldest_pc_i;
    logic        oldest_is_delayslot_i;
    logic [31:0] mem_addr_i;
    logic        mem_load_mis_i;
    logic        mem_store_mis_i;
    logic        exc_en_i;
    logic [31:0] pc_exc_i;
    logic        redirect_ready_i;
    logic [7:0]  exc_type_o;
    logic [31:0] victim_pc_o;
    logic        is_delayslot_o;
    logic [31:0] badvaddr_o;
    logic        flush_o;
    logic        mem_we_kill_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [15:0] exc_count_o;

    exc_ctrl #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stall_i               (stall_i),
        .ex_valid_i            (ex_valid_i),
        .ex_pc_i               (ex_pc_i),
        .ex_is_delayslot_i     (ex_is_delayslot_i),
        .ex_exc_i              (ex_exc_i),
        .oldest_pc_i           (oldest_pc_i),
        .oldest_is_delayslot_i (oldest_is_delayslot_i),
        .mem_addr_i            (mem_addr_i),
        .mem_load_mis_i        (mem_load_mis_i),
        .mem_store_mis_i       (mem_store_mis_i),
        .exc_en_i              (exc_en_i),
        .pc_exc_i              (pc_exc_i),
        .redirect_ready_i      (redirect_ready_i),
        .exc_type_o            (exc_type_o),
        .victim_pc_o           (victim_pc_o),
        .is_delayslot_o        (is_delayslot_o),
        .badvaddr_o            (badvaddr_o),
        .flush_o               (flush_o),
        .mem_we_kill_o         (mem_we_kill_o),
        .redirect_valid_o      (redirect_valid_o),
        .redirect_pc_o         (redirect_pc_o),
        .exc_count_o           (exc_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] v);
        item_t it;
        it.tag = tag;
        it.exp = v;
        sb.push_back(it);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        item_t it;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow observed=%h expected=<none>", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_redir(input string tag, input logic rv, input logic [31:0] rpc, input logic fl);
        push({tag, "_rvalid"}, 32'(rv));
        push({tag, "_rpc"},    rpc);
        push({tag, "_flush"},  32'(fl));
    endtask

    task automatic chk_redir();
        pop_chk(32'(redirect_valid_o));
        pop_chk(redirect_pc_o);
        pop_chk(32'(flush_o));
    endtask

    task automatic push_reset_vals(input string tag);
        push({tag, "_exc_type"}, 32'h0);
        push({tag, "_flush"},    32'h0);
        push({tag, "_kill"},     32'h0);
        push({tag, "_rvalid"},   32'h0);
        push({tag, "_rpc"},      32'h0);
        push({tag, "_count"},    32'h0);
        push({tag, "_victim"},   RST_PC);
        push({tag, "_ds"},       32'h0);
    endtask

    task automatic chk_reset_vals();
        pop_chk(32'(exc_type_o));
        pop_chk(32'(flush_o));
        pop_chk(32'(mem_we_kill_o));
        pop_chk(32'(redirect_valid_o));
        pop_chk(redirect_pc_o);
        pop_chk(32'(exc_count_o));
        pop_chk(victim_pc_o);
        pop_chk(32'(is_delayslot_o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; ex_valid_i = 1'b0; ex_pc_i = '0;
        ex_is_delayslot_i = 1'b0; ex_exc_i = '0; oldest_pc_i = 32'h8000_0777;
        oldest_is_delayslot_i = 1'b1; mem_addr_i = '0; mem_load_mis_i = 1'b0;
        mem_store_mis_i = 1'b0; exc_en_i = 1'b0; pc_exc_i = '0; redirect_ready_i = 1'b0;

        // Reset state: nothing seen yet, so victim is RESET_PC
        repeat (2) tick();
        push_reset_vals("rst");
        @(negedge clk);
        chk_reset_vals();
        tick();
        rst_n = 1'b1;

        // Syscall in EX
        tick();
        ex_valid_i = 1'b1; ex_pc_i = 32'h8000_0100; ex_exc_i = 8'h02;
        push("sys_ex_victim", 32'h8000_0100);
        @(negedge clk);
        pop_chk(victim_pc_o);
        tick();
        ex_valid_i = 1'b0; ex_exc_i = 8'h00; exc_en_i = 1'b1; pc_exc_i = VEC;
        push("sys_exc_type", 32'h02);
        push("sys_victim", 32'h8000_0100);
        push("sys_ds", 32'h0);
        push("sys_flush", 32'h1);
        push("sys_kill", 32'h1);
        push("sys_rvalid_pre", 32'h0);
        @(negedge clk);
        pop_chk(32'(exc_type_o));
        pop_chk(victim_pc_o);
        pop_chk(32'(is_delayslot_o));
        pop_chk(32'(flush_o));
        pop_chk(32'(mem_we_kill_o));
        pop_chk(32'(redirect_valid_o));
        tick();
        exc_en_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_redir("sys_hold", 1'b1, VEC, 1'b1);
            push("sys_hold_exc_type", 32'h0);
            push("sys_hold_kill", 32'h0);
            @(negedge clk);
            chk_redir();
            pop_chk(32'(exc_type_o));
            pop_chk(32'(mem_we_kill_o));
            tick();
        end
        redirect_ready_i = 1'b1;
        push_redir("sys_accept", 1'b1, VEC, 1'b1);
        @(negedge clk);
        chk_redir();
        tick();
        redirect_ready_i = 1'b0;
        push("sys_done_rvalid", 32'h0);
        push("sys_done_flush", 32'h0);
        push("sys_done_count", 32'h1);
        @(negedge clk);
        pop_chk(32'(redirect_valid_o));
        pop_chk(32'(flush_o));
        pop_chk(32'(exc_count_o));

        // Misaligned load, then address faults ignored when MEM is empty
        tick();
        ex_valid_i = 1'b1; ex_pc_i = 32'h8000_0180;
        tick();
        ex_valid_i = 1'b0; mem_load_mis_i = 1'b1; mem_addr_i = 32'h1001;
        push("ldmis_exc_type", 32'h40);
        push("ldmis_badvaddr", 32'h1001);
        @(negedge clk);
        pop_chk(32'(exc_type_o));
        pop_chk(badvaddr_o);
        tick();
        mem_load_mis_i = 1'b0; mem_store_mis_i = 1'b1;
        push("empty_exc_type", 32'h0);
        @(negedge clk);
        pop_chk(32'(exc_type_o));
        tick();
        mem_store_mis_i = 1'b0;

        // Misaligned store
        ex_valid_i = 1'b1; ex_pc_i = 32'h8000_0200;
        tick();
        ex_valid_i = 1'b0; mem_store_mis_i = 1'b1; mem_addr_i = 32'h1003;
        exc_en_i = 1'b1; pc_exc_i = VEC;
        push("st_exc_type", 32'h80);
        push("st_badvaddr", 32'h1003);
        push("st_kill", 32'h1);
        push("st_flush", 32'h1);
        @(negedge clk);
        pop_chk(32'(exc_type_o));
        pop_chk(badvaddr_o);
        pop_chk(32'(mem_we_kill_o));
        pop_chk(32'(flush_o));
        tick();
        exc_en_i = 1'b0; mem_store_mis_i = 1'b0; redirect_ready_i = 1'b1;
        push_redir("st_redir", 1'b1, VEC, 1'b1);
        @(negedge clk);
        chk_redir();
        tick();
        redirect_ready_i = 1'b0;
        push("st_count", 32'h2);
        push("st_done_rvalid", 32'h0);
        @(negedge clk);
        pop_chk(32'(exc_count_o));
        pop_chk(32'(redirect_valid_o));

        // Exception taken while MEM is stalled
        tick();
        ex_valid_i = 1'b1; ex_pc_i = 32'h8000_0300; ex_exc_i = 8'h04;
        tick();
        ex_valid_i = 1'b0; ex_exc_i = 8'h00; stall_i = 1'b1; exc_en_i = 1'b1;
        push("stall_exc_type", 32'h04);
        push("stall_flush", 32'h1);
        push("stall_kill", 32'h1);
        push("stall_count_pre", 32'h2);
        @(negedge clk);
        pop_chk(32'(exc_type_o));
        pop_chk(32'(flush_o));
        pop_chk(32'(mem_we_kill_o));
        pop_chk(32'(exc_count_o));
        tick();
        exc_en_i = 1'b0;
        push("stall_count_post", 32'h3);
        push("stall_redir_exc_type", 32'h0);
        @(negedge clk);
        pop_chk(32'(exc_count_o));
        pop_chk(32'(exc_type_o));
        tick();
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0; oldest_pc_i = 32'h8000_0999; oldest_is_delayslot_i = 1'b0;
        push("stall_memclr_victim", 32'h8000_0999);
        push("stall_memclr_exc_type", 32'h0);
        push("stall_count_final", 32'h3);
        @(negedge clk);
        pop_chk(victim_pc_o);
        pop_chk(32'(exc_type_o));
        pop_chk(32'(exc_count_o));
        tick();
        stall_i = 1'b0;

        // ERET then interrupt during REDIRECT, with ready in the same cycle
        ex_valid_i = 1'b1; ex_pc_i = 32'h8000_1000; ex_exc_i = 8'h20;
        tick();
        ex_valid_i = 1'b0; ex_exc_i = 8'h00; exc_en_i = 1'b1; pc_exc_i = 32'h8000_2000;
        push("eret_exc_type", 32'h20);
        push("eret_victim", 32'h8000_1000);
        @(negedge clk);
        pop_chk(32'(exc_type_o));
        pop_chk(victim_pc_o);
        tick();
        pc_exc_i = 32'h0000_0030; redirect_ready_i = 1'b1;
        push("int_victim", 32'h8000_2000);
        push("int_ds", 32'h0);
        push_redir("int_first", 1'b1, 32'h8000_2000, 1'b1);
        @(negedge clk);
        pop_chk(victim_pc_o);
        pop_chk(32'(is_delayslot_o));
        chk_redir();
        tick();
        exc_en_i = 1'b0; redirect_ready_i = 1'b0;
        push_redir("int_second", 1'b1, 32'h30, 1'b1);
        push("int_count", 32'h5);
        @(negedge clk);
        chk_redir();
        pop_chk(32'(exc_count_o));
        tick();
        redirect_ready_i = 1'b1;
        push_redir("int_accept", 1'b1, 32'h30, 1'b1);
        @(negedge clk);
        chk_redir();
        tick();
        redirect_ready_i = 1'b0;
        push("int_done_rvalid", 32'h0);
        push("int_done_flush", 32'h0);
        @(negedge clk);
        pop_chk(32'(redirect_valid_o));
        pop_chk(32'(flush_o));

        // Empty pipeline: victim comes from the oldest IF/ID instruction
        tick();
        oldest_pc_i = 32'h8000_0040; oldest_is_delayslot_i = 1'b1;
        push("empty_victim", 32'h8000_0040);
        push("empty_ds", 32'h1);
        @(negedge clk);
        pop_chk(victim_pc_o);
        pop_chk(32'(is_delayslot_o));
        tick();
        exc_en_i = 1'b1; pc_exc_i = VEC;
        tick();
        exc_en_i = 1'b0;
        push("empty_rvalid", 32'h1);
        push("empty_count", 32'h6);
        @(negedge clk);
        pop_chk(32'(redirect_valid_o));
        pop_chk(32'(exc_count_o));

        // Asynchronous reset in the middle of REDIRECT
        #2;
        rst_n = 1'b0;
        #1;
        push_reset_vals("midrst");
        chk_reset_vals();
        tick();
        rst_n = 1'b1;
        tick();
        push("postrst_rvalid", 32'h0);
        push("postrst_flush", 32'h0);
        @(negedge clk);
        pop_chk(32'(redirect_valid_o));
        pop_chk(32'(flush_o));

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- MEM-stage exception collector and pipeline-redirect controller. Directly upstream of, and closes the loop around, the CP0 block.
- Registers the EX→MEM exception payload and merges in the MEM-stage address faults. Drives CP0's exc_type/victim/delayslot/badvaddr inputs.
- Consumes CP0's exc_en/PC_exc and sequences the flush and the redirect handshake to fetch.

Parameters:
- RESET_PC, 32'hbfc00000, PC reported as victim when the pipeline is empty out of reset.
- CNT_W, 16, width of the saturating exception counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  MEM stage stall (hold MEM register)
- ex_valid_i  in  1  EX holds a valid instruction
- ex_pc_i  in  32  EX instruction PC
- ex_is_delayslot_i  in  1  EX instruction is in a delay slot
- ex_exc_i  in  8  exception flags accumulated by IF/ID/EX, in CP0 exc_type bit order
- oldest_pc_i  in  32  PC of the oldest instruction in IF/ID; valid when EX and MEM are empty
- oldest_is_delayslot_i  in  1  delay-slot flag for oldest_pc_i
- mem_addr_i  in  32  MEM-stage data address
- mem_load_mis_i  in  1  misaligned load in MEM (combinational)
- mem_store_mis_i  in  1  misaligned store in MEM (combinational)
- exc_en_i  in  1  CP0 exception/eret/interrupt taken this cycle
- pc_exc_i  in  32  CP0 redirect target
- redirect_ready_i  in  1  fetch accepts redirect
- exc_type_o  out  8  to CP0 exc_type
- victim_pc_o  out  32  to CP0 victim_inst_addr
- is_delayslot_o  out  1  to CP0 is_delayslot
- badvaddr_o  out  32  to CP0 badvaddr
- flush_o  out  1  invalidate IF/ID/EX and the MEM register
- mem_we_kill_o  out  1  suppress the MEM store/load side effect
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  32  redirect target
- exc_count_o  out  CNT_W  saturating count of taken exceptions

Behaviour:
- Exception bit map (package): [0] Bp, [1] Sys, [2] RI, [3] Ov, [4] Tr, [5] ERET, [6] AdEL, [7] AdES.
- MEM register (mem_valid, mem_pc, mem_ds, mem_exc):
  - Reset: all zero.
  - Loads EX inputs when !stall_i.
  - mem_valid is cleared on flush_o regardless of stall_i; flush wins.
- exc_type_o:
  - state==IDLE && mem_valid: mem_exc | {mem_store_mis_i, mem_load_mis_i & ~mem_exc[6], 6'b0}.
  - Otherwise 0. Purely combinational from registers and inputs.
- badvaddr_o = mem_addr_i. CP0 selects the PC itself for fetch faults.
- Victim selection, in priority order:
  - state==REDIRECT: redirect_pc_q, delayslot 0.
  - mem_valid: mem_pc, mem_ds.
  - ex_valid_i: ex_pc_i, ex_is_delayslot_i.
  - else: oldest_pc_i, oldest_is_delayslot_i.
  - Reset-empty case reports RESET_PC until the first valid instruction is seen (sticky seen_q bit).
- FSM states: IDLE, REDIRECT. Reset state: IDLE.
  - IDLE, exc_en_i=1: flush_o=1 and mem_we_kill_o=1 in the same cycle. Capture pc_exc_i into redirect_pc_q. Increment exc_count (saturate at all-ones). Next state REDIRECT. Accepted even when stall_i=1, because CP0 commits unconditionally.
  - REDIRECT: redirect_valid_o=1, redirect_pc_o=redirect_pc_q, flush_o=1.
    - redirect_valid_o and redirect_pc_o are held stable until redirect_ready_i.
    - On redirect_ready_i: go to IDLE; flush_o drops the following cycle.
  - REDIRECT with exc_en_i=1 (interrupt taken right after ERET): overwrite redirect_pc_q with pc_exc_i, increment the counter, stay in REDIRECT. If redirect_ready_i arrives the same cycle, the new target wins and the state stays REDIRECT one more handshake.
- Outputs at reset: exc_type_o=0, flush_o=0, mem_we_kill_o=0, redirect_valid_o=0, redirect_pc_o=0, exc_count_o=0.
- Reset mid-REDIRECT: returns to IDLE immediately; no redirect is issued.

Decomposition:
- Package exc_pkg: EXC_* bit-index constants, state enum, exception vector constants.
- Sub-module exc_mem_reg: the MEM payload register with flush/stall priority.

Test Plan:
- Syscall: ex_exc_i=8'h02, ex_pc=32'h8000_0100, no stall, CP0 returns exc_en with 32'hbfc00380.
  - exc_type_o=8'h02 and victim=32'h8000_0100 one cycle after EX.
  - flush_o pulses; redirect_valid_o held until ready, with redirect_pc_o=32'hbfc00380.
- Misaligned store: mem_store_mis_i=1, mem_addr_i=32'h1003.
  - exc_type_o=8'h80, badvaddr_o=32'h1003.
  - mem_we_kill_o=1 in the exc_en_i cycle.
- Stall plus exception: stall_i=1 when exc_en_i rises.
  - Flush is still asserted and mem_valid clears.
  - exc_count_o increments by exactly 1.
- ERET followed by interrupt: exc_en_i with 32'h8000_2000, then exc_en_i again in REDIRECT with 32'h30.
  - victim_pc_o=32'h8000_2000.
  - Final redirect_pc_o=32'h30; the count increases by 2.
- Empty pipeline interrupt: MEM and EX invalid, oldest_pc_i=32'h8000_0040, oldest_is_delayslot_i=1.
  - victim_pc_o=32'h8000_0040, is_delayslot_o=1.
- Reset asserted in REDIRECT with redirect_ready_i=0.
  - All outputs return to their reset values asynchronously; IDLE after release.
